// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the adder, multiplier and FP-to-int blocks.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } fp32_t;

  localparam int          FP32_BIAS    = 127;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Subnormals are treated as zero: this datapath flushes them.
  function automatic fp_class_e fp_classify(input fp32_t v);
    fp_class_e c;
    if (v.exponent == 8'h00) begin
      c = FP_ZERO;
    end else if (v.exponent == FP32_EXP_MAX) begin
      c = (v.fraction != 23'd0) ? FP_NAN : FP_INF;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational mantissa right-shift with round-to-nearest-even.
// Produces the rounded integer magnitude of mant * 2^-rshift, where mant is
// a 24-bit significand with the binary point below bit 23 already folded
// into rshift by the caller.
module fp_round_rne (
  input  logic [23:0] mant,
  input  logic [4:0]  rshift,
  output logic [24:0] mag
);

  logic [47:0] wide;
  logic [23:0] int_part;
  logic        guard;
  logic        sticky;
  logic        inc;

  // Shift with 24 fraction bits kept below the integer part, then RNE.
  always_comb begin
    wide     = {mant, 24'd0} >> rshift;
    int_part = wide[47:24];
    guard    = wide[23];
    sticky   = |wide[22:0];
    inc      = guard & (sticky | int_part[0]);
    mag      = {1'b0, int_part} + {24'd0, inc};
  end

endmodule

// File: rtl/fp32_to_int_quant.sv
// FP32 -> signed OUT_W-bit requantizer: scale by 2^i_shift, round RNE,
// saturate. Two-stage valid/ready pipeline, one item per cycle.
// Optional build macro FP2INT_RELU_EN: negative inputs produce 0 (no sat).
module fp32_to_int_quant
  import fp_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_data,
  input  logic signed [SHIFT_W-1:0] i_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat,
  output logic                      out_nan
);

  localparam int                    E_W     = 6;
  localparam logic signed [9:0]     E_LO10  = -10'sd2;
  localparam logic signed [9:0]     E_HI10  = 10'(OUT_W);
  localparam logic signed [E_W-1:0] E_HI    = E_W'(OUT_W);
  localparam logic [24:0]           POS_LIM = 25'((1 << (OUT_W - 1)) - 1);
  localparam logic [24:0]           NEG_LIM = 25'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0]      MAX_POS = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]      MIN_NEG = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
    logic             nan;
  } res_t;

  // Unbiased, scaled exponent limited to [-2, OUT_W]. Anything below -2
  // rounds to zero exactly like -2, and anything at or above OUT_W
  // saturates, so the clamp keeps shifts small without changing results.
  function automatic logic signed [E_W-1:0] clamp_exp(
    input logic [7:0]                bexp,
    input logic signed [SHIFT_W-1:0] sh
  );
    logic signed [9:0]     e;
    logic signed [E_W-1:0] r;
    e = $signed({2'b00, bexp}) - 10'(FP32_BIAS) + 10'(sh);
    if (e < E_LO10) begin
      r = E_W'(E_LO10);
    end else if (e > E_HI10) begin
      r = E_HI;
    end else begin
      r = E_W'(e);
    end
    return r;
  endfunction

  // Class handling, clamping and sign application on the rounded magnitude.
  function automatic res_t saturate(
    input fp_class_e   cls,
    input logic        sign,
    input logic [24:0] mag,
    input logic        at_max
  );
    res_t r;
    logic forced;
    r      = '0;
    forced = at_max || (cls == FP_INF);
    case (cls)
      FP_NAN:  r.nan = 1'b1;
      FP_ZERO: r     = '0;
      default: begin
        if (sign) begin
          if (forced || (mag > NEG_LIM)) begin
            r.data = MIN_NEG;
            r.sat  = 1'b1;
          end else begin
            r.data = OUT_W'(25'd0 - mag);
          end
        end else begin
          if (forced || (mag > POS_LIM)) begin
            r.data = MAX_POS;
            r.sat  = 1'b1;
          end else begin
            r.data = OUT_W'(mag);
          end
        end
      end
    endcase
`ifdef FP2INT_RELU_EN
    if (sign && (cls != FP_NAN)) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  fp32_t                 in_fp;
  logic                  ld1;
  logic                  ld2;

  logic                  vld_p1;
  logic                  sign_p1;
  logic [23:0]           mant_p1;
  logic signed [E_W-1:0] e_p1;
  fp_class_e             cls_p1;

  logic [4:0]            rshift_p1;
  logic [24:0]           mag_p1;
  res_t                  res_p1;

  assign in_fp    = in_data;
  assign ld2      = !out_valid || out_ready;
  assign ld1      = !vld_p1 || ld2;
  assign in_ready = ld1;

  // ---- stage 1: decode ----
  // Capture sign, significand, clamped exponent and class of the input.
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      sign_p1 <= in_fp.sign;
      mant_p1 <= {1'b1, in_fp.fraction};
      e_p1    <= clamp_exp(in_fp.exponent, i_shift);
      cls_p1  <= fp_classify(in_fp);
    end
  end

  // ---- stage 2: convert ----
  assign rshift_p1 = 5'(7'sd23 - 7'(e_p1));

  fp_round_rne u_round (
    .mant   (mant_p1),
    .rshift (rshift_p1),
    .mag    (mag_p1)
  );

  always_comb begin
    res_p1 = saturate(cls_p1, sign_p1, mag_p1, (e_p1 == E_HI));
  end

  // Pipe-enable control and registered outputs; reset flushes in-flight items.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_nan   <= 1'b0;
    end else begin
      if (ld1) begin
        vld_p1 <= in_valid;
      end
      if (ld2) begin
        out_valid <= vld_p1;
        if (vld_p1) begin
          out_data <= res_p1.data;
          out_sat  <= res_p1.sat;
          out_nan  <= res_p1.nan;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_to_int_quant.sv
// Scoreboard bench for fp32_to_int_quant (default OUT_W=8, SHIFT_W=6).
// Also valid for a build with FP2INT_RELU_EN defined.
module tb_fp32_to_int_quant;

  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 6;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_data;
  logic signed [SHIFT_W-1:0] i_shift;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_W-1:0]          out_data;
  logic                      out_sat;
  logic                      out_nan;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             s;
    logic             n;
  } exp_t;

  typedef struct packed {
    logic [31:0]               d;
    logic signed [SHIFT_W-1:0] sh;
    logic [OUT_W-1:0]          e;
    logic                      s;
    logic                      n;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV] = '{
    '{32'h3FC00000,  6'sd0,   8'h02, 1'b0, 1'b0},
    '{32'h40200000,  6'sd0,   8'h02, 1'b0, 1'b0},
    '{32'h40600000,  6'sd0,   8'h04, 1'b0, 1'b0},
    '{32'hBFC00000,  6'sd0,   8'hFE, 1'b0, 1'b0},
    '{32'h42FE0000,  6'sd0,   8'h7F, 1'b0, 1'b0},
    '{32'h43000000,  6'sd0,   8'h7F, 1'b1, 1'b0},
    '{32'hC3000000,  6'sd0,   8'h80, 1'b0, 1'b0},
    '{32'hC3010000,  6'sd0,   8'h80, 1'b1, 1'b0},
    '{32'h3F800000,  6'sd5,   8'h20, 1'b0, 1'b0},
    '{32'h3F800000, -6'sd1,   8'h00, 1'b0, 1'b0},
    '{32'h3FC00000, -6'sd1,   8'h01, 1'b0, 1'b0},
    '{32'h3F800000, -6'sd20,  8'h00, 1'b0, 1'b0},
    '{32'h3F800000,  6'sd30,  8'h7F, 1'b1, 1'b0},
    '{32'h7FC00000,  6'sd0,   8'h00, 1'b0, 1'b1},
    '{32'h7F800000,  6'sd0,   8'h7F, 1'b1, 1'b0},
    '{32'hFF800000,  6'sd0,   8'h80, 1'b1, 1'b0},
    '{32'h00000001,  6'sd0,   8'h00, 1'b0, 1'b0},
    '{32'h80000000,  6'sd0,   8'h00, 1'b0, 1'b0},
    '{32'h40A00000, -6'sd1,   8'h02, 1'b0, 1'b0},
    '{32'h3F400000,  6'sd0,   8'h01, 1'b0, 1'b0},
    '{32'hBF000000,  6'sd0,   8'h00, 1'b0, 1'b0}
  };

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp32_to_int_quant #(.OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .i_shift   (i_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_nan   (out_nan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one item starting at posedge+1; returns at posedge+1 after accept.
  task automatic send(input vec_t v);
    int   n;
    logic acc;
    exp_t e;
    e = '{v.e, v.s, v.n};
`ifdef FP2INT_RELU_EN
    if (v.d[31] && !(v.d[30:23] == 8'hFF && v.d[22:0] != 23'd0)) e = '0;
`endif
    in_valid = 1'b1;
    in_data  = v.d;
    i_shift  = v.sh;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) begin
      sbq.push_back(e);
    end else begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=%0d expected=<50", n);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Send into an empty pipe and measure cycles from accept to out_valid.
  task automatic lat_send(input vec_t v);
    int n;
    send(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", n, 2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every valid output is compared with the queue head,
  // so held values during a stall are checked each cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_data);
      end else begin
        chk("out_data", out_data, sbq[0].d);
        chk("out_sat", out_sat, sbq[0].s);
        chk("out_nan", out_nan, sbq[0].n);
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    i_shift   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_nan", out_nan, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    lat_send(vecs[0]);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) send(vecs[i]);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_full", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("full_rate", out_valid, 1);
        end
      end
    join
    drain();

    send(vecs[4]);
    send(vecs[5]);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_stale_out", out_valid, 0);
    end
    @(posedge clk);
    #1;
    lat_send(vecs[2]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
